// File: rtl/proc_ctrl_pkg.sv
// Shared types for the multicycle processor controller: FSM state encoding,
// decoder operation classes and a helper that classifies illegal op codes.
package proc_ctrl_pkg;

  localparam int OP_CLASS_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } ctrl_state_t;

  typedef enum logic [OP_CLASS_W-1:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_HALT   = 3'd4
  } op_class_t;

  // Codes above HALT have no defined meaning and stop the core with an error.
  function automatic logic is_illegal_op(input logic [OP_CLASS_W-1:0] op);
    return (op > 3'd4);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory-response wait timer. Counts cycles spent waiting in a request state;
// 'expired' flags the MEM_WAIT_MAX-th waiting cycle so the controller can give up
// unless a response arrives in that same cycle.
module wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [W-1:0] LAST = W'(MEM_WAIT_MAX - 1);

  logic [W-1:0] cnt_r;

  // Cycle counter: cleared on every state change, saturates on the final cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Sequencing controller for the non-pipelined core: FETCH, DECODE, EXECUTE,
// MEMORY, WRITEBACK with memory handshakes, response timeouts and a sticky error.
// Optional performance counters are built when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  imem_req,
  input  logic                  imem_rvalid,
  output logic                  ir_en,
  input  logic [OP_CLASS_W-1:0] op_class,
  input  logic                  branch_taken,
  output logic                  alu_en,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic                  rf_we,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  busy,
  output logic                  halted,
  output logic                  err
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instr_cnt
`endif
);

  ctrl_state_t state_r, state_next_s;
  op_class_t   op_q_r;
  logic        err_r;
  logic        set_err_s;
  logic        expired_s;
  logic        wait_clear_s;
  logic        wait_en_s;

  logic imem_req_s, ir_en_s, alu_en_s, dmem_req_s, dmem_we_s;
  logic rf_we_s, pc_inc_s, pc_load_s, busy_s, halted_s;

  // Wait timer runs only in the two request states and restarts on any transition.
  assign wait_en_s    = (state_r == ST_FETCH) || (state_r == ST_MEMORY);
  assign wait_clear_s = (state_next_s != state_r);

  wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_clear_s),
    .enable (wait_en_s),
    .expired(expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture the decoder class once in DECODE; later states see only this copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q_r <= OP_ALU;
    end else if (state_r == ST_DECODE) begin
      op_q_r <= op_class_t'(op_class);
    end else begin
      op_q_r <= op_q_r;
    end
  end

  // Sticky error flag: only a reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | set_err_s;
    end
  end

  // Next-state and output decode; ir_en and the retire pulses may follow inputs.
  always_comb begin
    state_next_s = state_r;
    set_err_s    = 1'b0;
    imem_req_s   = 1'b0;
    ir_en_s      = 1'b0;
    alu_en_s     = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    rf_we_s      = 1'b0;
    pc_inc_s     = 1'b0;
    pc_load_s    = 1'b0;
    busy_s       = 1'b0;
    halted_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        busy_s     = 1'b1;
        imem_req_s = 1'b1;
        if (imem_rvalid) begin
          ir_en_s      = 1'b1;
          state_next_s = ST_DECODE;
        end else if (expired_s) begin
          set_err_s    = 1'b1;
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        busy_s = 1'b1;
        if (op_class == OP_HALT) begin
          state_next_s = ST_HALT;
        end else if (is_illegal_op(op_class)) begin
          set_err_s    = 1'b1;
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        busy_s   = 1'b1;
        alu_en_s = 1'b1;
        case (op_q_r)
          OP_ALU:            state_next_s = ST_WRITEBACK;
          OP_LOAD, OP_STORE: state_next_s = ST_MEMORY;
          OP_BRANCH: begin
            pc_load_s    = branch_taken;
            pc_inc_s     = !branch_taken;
            state_next_s = ST_FETCH;
          end
          default: begin
            set_err_s    = 1'b1;
            state_next_s = ST_HALT;
          end
        endcase
      end
      ST_MEMORY: begin
        busy_s     = 1'b1;
        dmem_req_s = 1'b1;
        dmem_we_s  = (op_q_r == OP_STORE);
        if (dmem_ack) begin
          if (op_q_r == OP_STORE) begin
            pc_inc_s     = 1'b1;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_WRITEBACK;
          end
        end else if (expired_s) begin
          set_err_s    = 1'b1;
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_MEMORY;
        end
      end
      ST_WRITEBACK: begin
        busy_s       = 1'b1;
        rf_we_s      = 1'b1;
        pc_inc_s     = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_HALT: begin
        halted_s     = 1'b1;
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign imem_req = imem_req_s;
  assign ir_en    = ir_en_s;
  assign alu_en   = alu_en_s;
  assign dmem_req = dmem_req_s;
  assign dmem_we  = dmem_we_s;
  assign rf_we    = rf_we_s;
  assign pc_inc   = pc_inc_s;
  assign pc_load  = pc_load_s;
  assign busy     = busy_s;
  assign halted   = halted_s;
  assign err      = err_r;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] instr_cnt_r;

  // Busy-cycle and retired-instruction counters; both stop once halted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_r <= '0;
      instr_cnt_r <= '0;
    end else begin
      if (busy_s) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (pc_inc_s || pc_load_s) begin
        instr_cnt_r <= instr_cnt_r + CNT_W'(1);
      end else begin
        instr_cnt_r <= instr_cnt_r;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign instr_cnt = instr_cnt_r;
`endif

endmodule
